// File: rtl/avalon_pio_master.sv
// Single-outstanding Avalon-MM master: one command in, one read/write transfer, one response out.
// Define PIO_MASTER_TIMEOUT_EN to abort transfers stalled for more than TIMEOUT waitrequest cycles.
module avalon_pio_master #(
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    input  logic              waitrequest,
    input  logic [DATA_W-1:0] readdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("avalon_pio_master: TIMEOUT must be at least 1");
    end

    state_t              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [DATA_W-1:0]   writedata_q, writedata_d;
    logic                dir_q, dir_d;
    logic                read_q, read_d;
    logic                write_q, write_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

`ifdef PIO_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rsp_err_q, rsp_err_d;
`endif

    // NOTE: every _d gets a hold default first, so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        address_d   = address_q;
        writedata_d = writedata_q;
        dir_d       = dir_q;
        read_d      = read_q;
        write_d     = write_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef PIO_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = XFER;
                    cmd_ready_d = 1'b0;
                    address_d   = cmd_addr;
                    writedata_d = cmd_wdata;
                    dir_d       = cmd_write;
                    read_d      = ~cmd_write;
                    write_d     = cmd_write;
`ifdef PIO_MASTER_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            XFER: begin
                if (!waitrequest) begin
                    state_d     = RESP;
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = dir_q ? '0 : readdata;
`ifdef PIO_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    // Slave stalled too long: abandon the transfer and report an error.
                    state_d     = RESP;
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d       = cnt_q + CNT_W'(1);
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
                read_d      = 1'b0;
                write_d     = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            address_q   <= '0;
            writedata_q <= '0;
            dir_q       <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef PIO_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            dir_q       <= dir_d;
            read_q      <= read_d;
            write_q     <= write_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef PIO_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign address   = address_q;
    assign writedata = writedata_q;
    assign read      = read_q;
    assign write     = write_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
`ifdef PIO_MASTER_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_pio_master.sv
// Self-checking bench for avalon_pio_master: directed scenarios plus randomized transfers
// checked against a transaction-level model (strobe length, response data, error flag).
module tb_avalon_pio_master;

    localparam int ADDR_W  = 2;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest = 1'b0;
    logic [DATA_W-1:0] readdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    int passed = 0;
    int total  = 0;

    avalon_pio_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .address    (address),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .waitrequest(waitrequest),
        .readdata   (readdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One command/transfer/response. The slave stalls for `waits` cycles, then returns `rd`;
    // the bench holds off rsp_ready for `hold` cycles.
    task automatic run_xfer(input logic w, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input int waits, input int hold);
        int          n;
        int          exp_n;
        logic        exp_err;
        logic [31:0] exp_rdata;
        exp_err = 1'b0;
        exp_n   = waits + 1;
`ifdef PIO_MASTER_TIMEOUT_EN
        if (waits > TIMEOUT) begin
            exp_err = 1'b1;
            exp_n   = TIMEOUT + 1;
        end
`endif
        exp_rdata = (w || exp_err) ? 32'h0 : rd;

        check("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = wd;
        step();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = ADDR_W'($urandom);
        cmd_wdata = $urandom;
        check("cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);

        n = 0;
        while ((read || write) && n < 40) begin
            check("strobe_dir", {30'b0, read, write}, w ? 32'd1 : 32'd2);
            check("address", {30'b0, address}, {30'b0, a});
            check("writedata", writedata, wd);
            check("rsp_valid_in_xfer", {31'b0, rsp_valid}, 32'd0);
            waitrequest = (n < waits);
            readdata    = waitrequest ? $urandom : rd;
            step();
            n++;
        end
        waitrequest = 1'b0;
        readdata    = $urandom;
        check("strobe_cycles", n, exp_n);
        check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});

        for (int i = 0; i < hold; i++) begin
            step();
            check("rsp_valid_hold", {31'b0, rsp_valid}, 32'd1);
            check("rsp_rdata_hold", rsp_rdata, exp_rdata);
            check("rsp_err_hold", {31'b0, rsp_err}, {31'b0, exp_err});
            check("cmd_ready_resp", {31'b0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rsp_valid_clear", {31'b0, rsp_valid}, 32'd0);
        check("cmd_ready_back", {31'b0, cmd_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] q_data [3];
        logic        acc;
        int          idx;
        int          seen;
        int          last_cyc;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_read_write", {30'b0, read, write}, 32'd0);
        check("rst_address", {30'b0, address}, 32'd0);
        check("rst_writedata", writedata, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        reset = 1'b0;
        step();

        // Zero-wait write, then a stalled read with delayed response consumption
        run_xfer(1'b1, 2'd0, 32'h0000_007F, $urandom, 0, 0);
        run_xfer(1'b0, 2'd0, $urandom, 32'h0000_003C, 3, 5);

`ifdef PIO_MASTER_TIMEOUT_EN
        // Stuck slave times out; release exactly on the last tolerated cycle completes normally
        run_xfer(1'b0, 2'd1, $urandom, $urandom, 100, 1);
        run_xfer(1'b0, 2'd2, $urandom, 32'hA5A5_0F0F, TIMEOUT, 0);
`endif

        // Reset in the middle of a stalled read abandons it
        cmd_valid   = 1'b1;
        cmd_write   = 1'b0;
        cmd_addr    = 2'd1;
        step();
        cmd_valid   = 1'b0;
        waitrequest = 1'b1;
        check("pre_reset_read", {31'b0, read}, 32'd1);
        step();
        reset = 1'b1;
        step();
        reset       = 1'b0;
        waitrequest = 1'b0;
        check("mid_reset_read", {31'b0, read}, 32'd0);
        check("mid_reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("mid_reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        repeat (2) begin
            step();
            check("post_reset_quiet", {29'b0, rsp_valid, read, write}, 32'd0);
        end
        run_xfer(1'b0, 2'd3, $urandom, $urandom, 1, 0);

        // Back-to-back writes with cmd_valid held high and rsp_ready tied high
        for (int i = 0; i < 3; i++) q_data[i] = $urandom;
        idx         = 0;
        seen        = 0;
        last_cyc    = 0;
        rsp_ready   = 1'b1;
        waitrequest = 1'b0;
        cmd_valid   = 1'b1;
        cmd_write   = 1'b1;
        cmd_addr    = 2'd2;
        cmd_wdata   = q_data[0];
        for (int cyc = 0; cyc < 20; cyc++) begin
            acc = cmd_valid && cmd_ready;
            step();
            if (acc) begin
                idx++;
                if (idx < 3) cmd_wdata = q_data[idx];
                else cmd_valid = 1'b0;
            end
            if (write) begin
                if (seen < 3) check("b2b_data", writedata, q_data[seen]);
                if (seen > 0) check("b2b_gap", cyc - last_cyc, 32'd3);
                last_cyc = cyc;
                seen++;
            end
        end
        rsp_ready = 1'b0;
        check("b2b_count", seen, 32'd3);

        // Randomized transfers against the transaction model
        for (int i = 0; i < 12; i++) begin
            run_xfer(1'($urandom), ADDR_W'($urandom), $urandom, $urandom,
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/avalon_pio_master.md
AVALON_PIO_MASTER -- requirements
Module: avalon_pio_master

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_W, 2, Avalon word address width.
- DATA_W, 32, Avalon data width.
- TIMEOUT, 255, maximum waitrequest cycles tolerated per transfer.

REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are high on the same edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target word address.
- cmd_wdata  in  DATA_W  write data.
- address  out  ADDR_W  Avalon-MM master address.
- read  out  1  Avalon read strobe.
- write  out  1  Avalon write strobe.
- writedata  out  DATA_W  Avalon write data.
- waitrequest  in  1  slave stall.
- readdata  in  DATA_W  slave read data, zero read latency.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  captured read data; 0 for writes.
- rsp_err  out  1  transfer aborted by timeout.

Function
REQ-003 The FSM SHALL have states IDLE, XFER and RESP.
REQ-004 cmd_ready SHALL be high only in IDLE.
REQ-005 On command acceptance, the FSM SHALL go to XFER and register cmd_addr, cmd_wdata and cmd_write into address, writedata and an internal direction bit.
REQ-006 In XFER, read SHALL equal the inverted direction bit, write SHALL equal the direction bit, and address and writedata SHALL be held stable.
REQ-007 A transfer SHALL complete on the first edge in XFER with waitrequest low.
- Reads capture readdata into rsp_rdata on that edge.
- Writes load rsp_rdata with 0.
- rsp_err is cleared.
- The FSM goes to RESP.
REQ-008 read and write SHALL deassert on the completion edge and never be high together; minimum transfer = 1 XFER cycle.
REQ-009 In RESP, rsp_valid SHALL be high and rsp_rdata and rsp_err held stable until rsp_valid and rsp_ready are high on the same edge; the FSM then returns to IDLE.
REQ-010 No new command SHALL be accepted on the RESP-exit edge. Back-to-back throughput SHALL be 1 command per 3 cycles at zero wait.
REQ-011 Command-to-strobe latency SHALL be 1 cycle, and strobe-to-rsp_valid latency SHALL be 1 cycle after the completion edge.
REQ-012 Changes on cmd_* inputs outside the acceptance edge SHALL have no effect.

Reset
REQ-013 reset high on any edge SHALL force IDLE, including mid-XFER: the strobe drops next cycle and the transfer is abandoned with no response.
REQ-014 The reset value of every output SHALL be 0, except cmd_ready, which SHALL be 1 once in IDLE.
REQ-015 reset SHALL clear the timeout counter; reset has priority over all other events.

Configuration
REQ-016 With macro PIO_MASTER_TIMEOUT_EN defined:
- A counter of width clog2(TIMEOUT+1) SHALL clear on XFER entry and increment each XFER cycle with waitrequest high.
- When waitrequest is still high with the count equal to TIMEOUT, strobes SHALL drop, rsp_err SHALL be set to 1, rsp_rdata SHALL be set to 0, and the FSM SHALL go to RESP.
- waitrequest going low on that same edge SHALL count as normal completion, not error.
REQ-017 Without PIO_MASTER_TIMEOUT_EN, no counter SHALL exist, XFER SHALL wait indefinitely, and rsp_err SHALL be constant 0.

Verification
REQ-018 Write cmd addr=0, wdata=0x0000007F, waitrequest=0 -> write high 1 cycle with address=0, writedata=0x7F; rsp_valid next cycle; rsp_rdata=0, rsp_err=0.
REQ-019 Read addr=0, waitrequest high 3 cycles then low with readdata=0x3C -> read high 4 cycles; rsp_rdata=0x3C; rsp_valid held while rsp_ready=0 for 5 cycles.
REQ-020 (TIMEOUT_EN, TIMEOUT=4) Read with waitrequest stuck high -> read drops after 5 XFER cycles; rsp_err=1, rsp_rdata=0.
REQ-021 (TIMEOUT_EN, TIMEOUT=4) waitrequest falls exactly on the 5th XFER cycle -> normal completion, rsp_err=0.
REQ-022 reset asserted for 1 cycle during XFER with waitrequest high -> read=0 the following cycle, no rsp_valid, cmd_ready=1; the next command completes normally.
REQ-023 cmd_valid held high with 3 queued writes and rsp_ready=1 -> exactly 3 write strobes, each 3 cycles apart, data in order.
